// File: rtl/pipe_hazard_ctrl.sv
// Five-stage MIPS pipeline sequencing: load-use, redirect, imem wait and MDU-busy stalls.
// Optional multiply/divide occupancy tracking is built when PIPE_CTRL_MDU_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned PERF_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [4:0]        i_id_rs,
  input  logic [4:0]        i_id_rt,
  input  logic              i_id_uses_rt,
  input  logic              i_ex_memread,
  input  logic [4:0]        i_ex_rt,
  input  logic              i_redirect,
  input  logic              i_imem_ready,
  input  logic              i_mdu_start,
  input  logic              i_id_mdu_use,
  output logic              o_pc_we,
  output logic              o_ifid_we,
  output logic              o_ifid_flush,
  output logic              o_idex_flush,
  output logic              o_mdu_busy,
  output logic [1:0]        o_state,
  output logic [PERF_W-1:0] o_stall_cycles
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IMISS = 2'd1,
    DROP  = 2'd2,
    BAD   = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic                lu, mh;
  logic [PERF_W-1:0]   stall_cnt;

  assign lu = i_ex_memread && (i_ex_rt != '0) &&
              ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));

`ifdef PIPE_CTRL_MDU_EN
  localparam int unsigned CNT_W = 6;
  logic [CNT_W-1:0] mdu_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      mdu_cnt <= '0;
    else if (i_mdu_start)
      mdu_cnt <= CNT_W'(MDU_LATENCY);
    else if (mdu_cnt != '0)
      mdu_cnt <= mdu_cnt - 1'b1;
  end

  assign o_mdu_busy = (mdu_cnt != '0);
  assign mh         = o_mdu_busy && i_id_mdu_use;
`else
  logic unused_mdu;
  assign unused_mdu = ^{i_mdu_start, i_id_mdu_use};
  assign o_mdu_busy = 1'b0;
  assign mh         = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      state <= RUN;
    else
      state <= state_nx;
  end

  always_comb begin
    o_pc_we      = 1'b0;
    o_ifid_we    = 1'b0;
    o_ifid_flush = 1'b0;
    o_idex_flush = 1'b0;
    state_nx     = state;
    if (!i_rst_n) begin
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
      state_nx     = RUN;
    end else if (i_redirect) begin
      o_pc_we      = 1'b1;
      o_ifid_flush = 1'b1;
      o_idex_flush = 1'b1;
      state_nx     = i_imem_ready ? RUN : DROP;
    end else if (lu || mh) begin
      o_idex_flush = 1'b1;
      if (!i_imem_ready)
        state_nx = (state == DROP) ? DROP : IMISS;
      else
        state_nx = RUN;
    end else if (state == DROP) begin
      o_ifid_flush = 1'b1;
      state_nx     = i_imem_ready ? RUN : DROP;
    end else if (!i_imem_ready) begin
      o_ifid_flush = 1'b1;
      state_nx     = IMISS;
    end else begin
      o_pc_we   = 1'b1;
      o_ifid_we = 1'b1;
      state_nx  = RUN;
    end
    // Unreachable encoding recovers to RUN regardless of which rule fired.
    if (state == BAD)
      state_nx = RUN;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      stall_cnt <= '0;
    else if (!o_pc_we && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign o_state        = state;
  assign o_stall_cycles = stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver pushes hand-computed expectations, monitor compares.
module tb_pipe_hazard_ctrl;
  localparam int unsigned PW = 4;
`ifdef PIPE_CTRL_MDU_EN
  localparam logic MON = 1'b1;
`else
  localparam logic MON = 1'b0;
`endif
  localparam logic [3:0] RUNC = 4'b1100; // {pc_we, ifid_we, ifid_flush, idex_flush}
  localparam logic [3:0] LUC  = 4'b0001;
  localparam logic [3:0] RDC  = 4'b1011;
  localparam logic [3:0] FLC  = 4'b0010;
  localparam logic [3:0] RSC  = 4'b0011;
  localparam logic [3:0] MHC  = MON ? LUC : RUNC;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    id_rs = '0, id_rt = '0, ex_rt = '0;
  logic          id_uses_rt = 1'b0, ex_memread = 1'b0, redirect = 1'b0;
  logic          imem_ready = 1'b1, mdu_start = 1'b0, id_mdu_use = 1'b0;
  logic          pc_we, ifid_we, ifid_flush, idex_flush, mdu_busy;
  logic [1:0]    state;
  logic [PW-1:0] stall_cycles;

  typedef struct {
    string           nm;
    logic [PW+6:0]   v;
  } exp_t;

  exp_t          sb[$];
  int            n_pass = 0;
  int            n_total = 0;
  logic [PW-1:0] stall_m = '0;

  pipe_hazard_ctrl #(.MDU_LATENCY(4), .PERF_W(PW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rt(id_uses_rt), .i_ex_memread(ex_memread), .i_ex_rt(ex_rt),
    .i_redirect(redirect), .i_imem_ready(imem_ready), .i_mdu_start(mdu_start),
    .i_id_mdu_use(id_mdu_use), .o_pc_we(pc_we), .o_ifid_we(ifid_we),
    .o_ifid_flush(ifid_flush), .o_idex_flush(idex_flush), .o_mdu_busy(mdu_busy),
    .o_state(state), .o_stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic cyc(input string nm, input logic rst, input logic rd, input logic rdy,
                     input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                     input logic [4:0] rt, input logic urt, input logic st_mdu,
                     input logic use_mdu, input logic [3:0] ctl, input logic [1:0] st,
                     input logic bsy);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; redirect = rd; imem_ready = rdy; ex_memread = mr; ex_rt = ert;
    id_rs = rs; id_rt = rt; id_uses_rt = urt; mdu_start = st_mdu; id_mdu_use = use_mdu;
    e.nm = nm;
    e.v  = {ctl, st, bsy, stall_m};
    sb.push_back(e);
    if (!rst)
      stall_m = '0;
    else if (!ctl[3] && stall_m != '1)
      stall_m = stall_m + 1'b1;
  endtask

  task automatic idle(input string nm, input logic rdy, input logic [3:0] ctl,
                      input logic [1:0] st, input logic bsy);
    cyc(nm, 1, 0, rdy, 0, 0, 0, 0, 0, 0, 0, ctl, st, bsy);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      logic [PW+6:0] act;
      e   = sb.pop_front();
      act = {pc_we, ifid_we, ifid_flush, idex_flush, state, mdu_busy, stall_cycles};
      n_total++;
      if (act === e.v)
        n_pass++;
      else
        $display("FAIL %s: got %b want %b (pcwe,ifidwe,ifidfl,idexfl,state,busy,stalls)",
                 e.nm, act, e.v);
    end
  end

  initial begin
    @(posedge clk);
    //   name             rst rd rdy mr ert rs rt urt st use ctl   st busy
    cyc("reset",          0,  0, 1,  0, 0,  0, 0, 0,  0, 0,  RSC,  0, 0);
    idle("run", 1, RUNC, 0, 0);
    cyc("lu_rs",          1,  0, 1,  1, 8,  8, 0, 0,  0, 0,  LUC,  0, 0);
    idle("lu_release", 1, RUNC, 0, 0);
    cyc("zero_reg",       1,  0, 1,  1, 0,  0, 0, 1,  0, 0,  RUNC, 0, 0);
    cyc("lu_rt",          1,  0, 1,  1, 9,  3, 9, 1,  0, 0,  LUC,  0, 0);
    cyc("rt_not_used",    1,  0, 1,  1, 9,  3, 9, 0,  0, 0,  RUNC, 0, 0);
    cyc("redir_miss",     1,  1, 0,  0, 0,  0, 0, 0,  0, 0,  RDC,  0, 0);
    idle("drop1", 0, FLC, 2, 0);
    idle("drop2", 0, FLC, 2, 0);
    idle("drop3_ready", 1, FLC, 2, 0);
    idle("run_after_drop", 1, RUNC, 0, 0);
    idle("imiss_enter", 0, FLC, 0, 0);
    idle("imiss_hold", 0, FLC, 1, 0);
    idle("imiss_done", 1, RUNC, 1, 0);
    cyc("prio_redir_lu",  1,  1, 1,  1, 8,  8, 0, 0,  0, 0,  RDC,  0, 0);
    cyc("lu_in_miss",     1,  0, 0,  1, 8,  8, 0, 0,  0, 0,  LUC,  0, 0);
    idle("after_lu_miss", 1, RUNC, 1, 0);
    cyc("redir_miss2",    1,  1, 0,  0, 0,  0, 0, 0,  0, 0,  RDC,  0, 0);
    cyc("lu_in_drop",     1,  0, 0,  1, 8,  8, 0, 0,  0, 0,  LUC,  2, 0);
    idle("drop_ready", 1, FLC, 2, 0);
    idle("run2", 1, RUNC, 0, 0);
    cyc("mdu_start",      1,  0, 1,  0, 0,  0, 0, 0,  1, 0,  RUNC, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc("mdu_wait",     1,  0, 1,  0, 0,  0, 0, 0,  0, 1,  MHC,  0, MON);
    cyc("mdu_proceed",    1,  0, 1,  0, 0,  0, 0, 0,  0, 1,  RUNC, 0, 0);
    cyc("mdu_start2",     1,  0, 1,  0, 0,  0, 0, 0,  1, 0,  RUNC, 0, 0);
    cyc("mdu_wait2",      1,  0, 1,  0, 0,  0, 0, 0,  0, 1,  MHC,  0, MON);
    cyc("mdu_restart",    1,  0, 1,  0, 0,  0, 0, 0,  1, 1,  MHC,  0, MON);
    for (int i = 0; i < 4; i++)
      cyc("mdu_wait3",    1,  0, 1,  0, 0,  0, 0, 0,  0, 1,  MHC,  0, MON);
    cyc("mdu_proceed2",   1,  0, 1,  0, 0,  0, 0, 0,  0, 1,  RUNC, 0, 0);
    idle("sat_enter", 0, FLC, 0, 0);
    for (int i = 0; i < 12; i++)
      idle("sat_hold", 0, FLC, 1, 0);
    idle("sat_done", 1, RUNC, 1, 0);
    cyc("rst_mdu",        1,  0, 1,  0, 0,  0, 0, 0,  1, 0,  RUNC, 0, 0);
    cyc("rst_redir",      1,  1, 0,  0, 0,  0, 0, 0,  0, 0,  RDC,  0, MON);
    cyc("rst_in_drop",    0,  0, 0,  0, 0,  0, 0, 0,  0, 0,  RSC,  2, MON);
    idle("after_reset", 1, RUNC, 0, 0);
    for (int i = 0; i < 10 && sb.size() != 0; i++)
      @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
